// File: rtl/polygon_dispatcher.sv
// polygon_dispatcher
//
// Scans a polygon table once per requested pixel and turns each enabled
// table entry into a vertex list for the downstream determinant stage.
// Each scan starts with one bubble cycle that marks the pixel boundary.
// After that, one table entry is emitted per cycle.
//
// Ports
//   clk                  sole clock, rising edge
//   reset                asynchronous, active-high reset
//   pixel_start          one-cycle scan request (ignored while busy)
//   pixel_x, pixel_y     pixel coordinates, sampled on an accepted request
//   mem_addr             registered polygon table read address
//   mem_data             table word, valid one cycle after mem_addr
//                        [39] enable, [38] form, [37:29] color,
//                        [28:19] cx, [18:9] cy, [8:0] size
//   st3_bubble           pixel-boundary marker
//   st3_color            color of the presented polygon
//   st3_pixel_x/y        pixel currently being scanned
//   form                 0 square, 1 triangle
//   v1..v4 _x/_y         polygon vertices, saturated to [0,1023]
//   busy                 scan in progress
//   done                 one-cycle pulse after the last entry was presented
module polygon_dispatcher #(
    parameter int N_POLY = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_start,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [39:0]       mem_data,
    output logic              st3_bubble,
    output logic [8:0]        st3_color,
    output logic [9:0]        st3_pixel_x,
    output logic [9:0]        st3_pixel_y,
    output logic              form,
    output logic [9:0]        v1_x,
    output logic [9:0]        v1_y,
    output logic [9:0]        v2_x,
    output logic [9:0]        v2_y,
    output logic [9:0]        v3_x,
    output logic [9:0]        v3_y,
    output logic [9:0]        v4_x,
    output logic [9:0]        v4_y,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POLY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUBBLE = 2'd1,
        FETCH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] ent_q, ent_d;
    logic [9:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic              st3_bubble_q, st3_bubble_d;
    logic [8:0]        st3_color_q, st3_color_d;
    logic [9:0]        st3_pixel_x_q, st3_pixel_x_d, st3_pixel_y_q, st3_pixel_y_d;
    logic              form_q, form_d;
    logic [9:0]        v1_x_q, v1_x_d, v1_y_q, v1_y_d;
    logic [9:0]        v2_x_q, v2_x_d, v2_y_q, v2_y_d;
    logic [9:0]        v3_x_q, v3_x_d, v3_y_q, v3_y_d;
    logic [9:0]        v4_x_q, v4_x_d, v4_y_q, v4_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Table word fields
    logic              ent_en;
    logic              ent_form;
    logic [8:0]        ent_color;
    logic [9:0]        ent_cx, ent_cy;
    logic [8:0]        ent_size;

    assign ent_en    = mem_data[39];
    assign ent_form  = mem_data[38];
    assign ent_color = mem_data[37:29];
    assign ent_cx    = mem_data[28:19];
    assign ent_cy    = mem_data[18:9];
    assign ent_size  = mem_data[8:0];

    // cx+size can reach 1534, so the intermediates carry one bit more than
    // a bare 11-bit signed value. This avoids wrap-around before clamping.
    logic signed [11:0] cx_lo, cx_hi, cy_lo, cy_hi;

    always_comb begin
        cx_lo = signed'({2'b00, ent_cx}) - signed'({3'b000, ent_size});
        cx_hi = signed'({2'b00, ent_cx}) + signed'({3'b000, ent_size});
        cy_lo = signed'({2'b00, ent_cy}) - signed'({3'b000, ent_size});
        cy_hi = signed'({2'b00, ent_cy}) + signed'({3'b000, ent_size});
    end

    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        if (v < 12'sd0) begin
            return 10'd0;
        end else if (v > 12'sd1023) begin
            return 10'd1023;
        end else begin
            return v[9:0];
        end
    endfunction

    // State and output registers. Every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            ent_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            st3_bubble_q  <= 1'b0;
            st3_color_q   <= '0;
            st3_pixel_x_q <= '0;
            st3_pixel_y_q <= '0;
            form_q        <= 1'b0;
            v1_x_q        <= '0;
            v1_y_q        <= '0;
            v2_x_q        <= '0;
            v2_y_q        <= '0;
            v3_x_q        <= '0;
            v3_y_q        <= '0;
            v4_x_q        <= '0;
            v4_y_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            ent_q         <= ent_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            st3_bubble_q  <= st3_bubble_d;
            st3_color_q   <= st3_color_d;
            st3_pixel_x_q <= st3_pixel_x_d;
            st3_pixel_y_q <= st3_pixel_y_d;
            form_q        <= form_d;
            v1_x_q        <= v1_x_d;
            v1_y_q        <= v1_y_d;
            v2_x_q        <= v2_x_d;
            v2_y_q        <= v2_y_d;
            v3_x_q        <= v3_x_d;
            v3_y_q        <= v3_y_d;
            v4_x_q        <= v4_x_d;
            v4_y_q        <= v4_y_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic and output logic.
    // Outputs are loaded on the edge that enters a state.
    // The bubble values are loaded on the edge that accepts the request.
    // The first FETCH cycle sees the data for address 0.
    // ent_q counts captured entries. mem_addr stops at the last address
    // one cycle before the last entry arrives.
    // DRAIN is the cycle in which that last entry is on the outputs.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        ent_d         = ent_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        st3_bubble_d  = 1'b0;
        st3_color_d   = st3_color_q;
        st3_pixel_x_d = st3_pixel_x_q;
        st3_pixel_y_d = st3_pixel_y_q;
        form_d        = form_q;
        v1_x_d        = v1_x_q;
        v1_y_d        = v1_y_q;
        v2_x_d        = v2_x_q;
        v2_y_d        = v2_y_q;
        v3_x_d        = v3_x_q;
        v3_y_d        = v3_y_q;
        v4_x_d        = v4_x_q;
        v4_y_d        = v4_y_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pixel_start) begin
                    state_d       = BUBBLE;
                    busy_d        = 1'b1;
                    mem_addr_d    = '0;
                    ent_d         = '0;
                    pix_x_d       = pixel_x;
                    pix_y_d       = pixel_y;
                    st3_bubble_d  = 1'b1;
                    st3_color_d   = '0;
                    st3_pixel_x_d = pixel_x;
                    st3_pixel_y_d = pixel_y;
                    form_d        = 1'b0;
                    v1_x_d        = '0;
                    v1_y_d        = '0;
                    v2_x_d        = '0;
                    v2_y_d        = '0;
                    v3_x_d        = '0;
                    v3_y_d        = '0;
                    v4_x_d        = '0;
                    v4_y_d        = '0;
                end
            end

            BUBBLE: begin
                state_d    = FETCH;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            end

            FETCH: begin
                if (mem_addr_q != LAST) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                // A disabled entry leaves the previous presentation in place.
                if (ent_en) begin
                    st3_color_d   = ent_color;
                    st3_pixel_x_d = pix_x_q;
                    st3_pixel_y_d = pix_y_q;
                    form_d        = ent_form;
                    if (ent_form) begin
                        v1_x_d = ent_cx;
                        v1_y_d = sat10(cy_lo);
                        v2_x_d = sat10(cx_hi);
                        v2_y_d = sat10(cy_hi);
                        v3_x_d = sat10(cx_lo);
                        v3_y_d = sat10(cy_hi);
                        v4_x_d = '0;
                        v4_y_d = '0;
                    end else begin
                        v1_x_d = sat10(cx_lo);
                        v1_y_d = sat10(cy_lo);
                        v2_x_d = sat10(cx_hi);
                        v2_y_d = sat10(cy_lo);
                        v3_x_d = sat10(cx_hi);
                        v3_y_d = sat10(cy_hi);
                        v4_x_d = sat10(cx_lo);
                        v4_y_d = sat10(cy_hi);
                    end
                end
                if (ent_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    ent_d = ent_q + ADDR_W'(1);
                end
            end

            DRAIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mem_addr    = mem_addr_q;
    assign st3_bubble  = st3_bubble_q;
    assign st3_color   = st3_color_q;
    assign st3_pixel_x = st3_pixel_x_q;
    assign st3_pixel_y = st3_pixel_y_q;
    assign form        = form_q;
    assign v1_x        = v1_x_q;
    assign v1_y        = v1_y_q;
    assign v2_x        = v2_x_q;
    assign v2_y        = v2_y_q;
    assign v3_x        = v3_x_q;
    assign v3_y        = v3_y_q;
    assign v4_x        = v4_x_q;
    assign v4_y        = v4_y_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_polygon_dispatcher.sv
// tb_polygon_dispatcher
//
// Directed bench for polygon_dispatcher with a four-entry table.
// A registered memory model answers mem_addr one cycle later.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_polygon_dispatcher;

    logic        clk;
    logic        reset;
    logic        pixelStart;
    logic [9:0]  pixelX, pixelY;
    logic [1:0]  memAddr;
    logic [39:0] memData;
    logic        st3Bubble;
    logic [8:0]  st3Color;
    logic [9:0]  st3PixelX, st3PixelY;
    logic        formOut;
    logic [9:0]  v1x, v1y, v2x, v2y, v3x, v3y, v4x, v4y;
    logic        busy, done;

    logic [39:0] polyMem [4];
    int          testsRun;
    int          testsFailed;

    polygon_dispatcher #(.N_POLY(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_start (pixelStart),
        .pixel_x     (pixelX),
        .pixel_y     (pixelY),
        .mem_addr    (memAddr),
        .mem_data    (memData),
        .st3_bubble  (st3Bubble),
        .st3_color   (st3Color),
        .st3_pixel_x (st3PixelX),
        .st3_pixel_y (st3PixelY),
        .form        (formOut),
        .v1_x        (v1x),
        .v1_y        (v1y),
        .v2_x        (v2x),
        .v2_y        (v2y),
        .v3_x        (v3x),
        .v3_y        (v3y),
        .v4_x        (v4x),
        .v4_y        (v4y),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Table memory with one cycle of read latency
    always @(posedge clk) begin
        memData <= polyMem[memAddr];
    end

    function automatic logic [39:0] mkEntry(input logic en, input logic frm,
                                            input int color, input int cx,
                                            input int cy, input int sz);
        logic [8:0] c9;
        logic [9:0] x10;
        logic [9:0] y10;
        logic [8:0] s9;
        c9  = color[8:0];
        x10 = cx[9:0];
        y10 = cy[9:0];
        s9  = sz[8:0];
        return {en, frm, c9, x10, y10, s9};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkPoly(input string tag,
                             input int ex1, input int ey1, input int ex2, input int ey2,
                             input int ex3, input int ey3, input int ex4, input int ey4,
                             input int eForm, input int eColor, input int ePx, input int ePy);
        checkOutput({tag, ".v1x"}, 32'(v1x), ex1);
        checkOutput({tag, ".v1y"}, 32'(v1y), ey1);
        checkOutput({tag, ".v2x"}, 32'(v2x), ex2);
        checkOutput({tag, ".v2y"}, 32'(v2y), ey2);
        checkOutput({tag, ".v3x"}, 32'(v3x), ex3);
        checkOutput({tag, ".v3y"}, 32'(v3y), ey3);
        checkOutput({tag, ".v4x"}, 32'(v4x), ex4);
        checkOutput({tag, ".v4y"}, 32'(v4y), ey4);
        checkOutput({tag, ".form"}, 32'(formOut), eForm);
        checkOutput({tag, ".color"}, 32'(st3Color), eColor);
        checkOutput({tag, ".pixx"}, 32'(st3PixelX), ePx);
        checkOutput({tag, ".pixy"}, 32'(st3PixelY), ePy);
    endtask

    task automatic checkCtrl(input string tag, input int eBubble, input int eAddr,
                             input int eBusy, input int eDone);
        checkOutput({tag, ".bubble"}, 32'(st3Bubble), eBubble);
        checkOutput({tag, ".addr"}, 32'(memAddr), eAddr);
        checkOutput({tag, ".busy"}, 32'(busy), eBusy);
        checkOutput({tag, ".done"}, 32'(done), eDone);
    endtask

    task automatic applyStimulus(input logic start, input int x, input int y);
        pixelStart = start;
        pixelX     = x[9:0];
        pixelY     = y[9:0];
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        polyMem[0] = mkEntry(1'b1, 1'b0, 37, 200, 120, 10);
        polyMem[1] = mkEntry(1'b1, 1'b1, 5, 5, 1020, 20);
        polyMem[2] = mkEntry(1'b0, 1'b0, 99, 600, 600, 100);
        polyMem[3] = mkEntry(1'b1, 1'b0, 300, 1000, 3, 50);

        reset = 1'b1;
        applyStimulus(1'b0, 0, 0);
        step();
        step();
        checkCtrl("reset", 0, 0, 0, 0);
        checkPoly("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Cycle T: request pixel (100,50)
        step();
        applyStimulus(1'b1, 100, 50);

        step();  // T+1: bubble
        applyStimulus(1'b0, 0, 0);
        checkCtrl("t1", 1, 0, 1, 0);
        checkPoly("t1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 100, 50);

        step();  // T+2: request while busy must be ignored
        applyStimulus(1'b1, 7, 9);
        checkCtrl("t2", 0, 1, 1, 0);

        step();  // T+3: entry 0 square
        applyStimulus(1'b0, 0, 0);
        checkCtrl("t3", 0, 2, 1, 0);
        checkPoly("t3", 190, 110, 210, 110, 210, 130, 190, 130, 0, 37, 100, 50);

        step();  // T+4: entry 1 triangle with saturation
        checkCtrl("t4", 0, 3, 1, 0);
        checkPoly("t4", 5, 1000, 25, 1023, 0, 1023, 0, 0, 1, 5, 100, 50);

        step();  // T+5: entry 2 disabled, hold T+4
        checkCtrl("t5", 0, 3, 1, 0);
        checkPoly("t5", 5, 1000, 25, 1023, 0, 1023, 0, 0, 1, 5, 100, 50);

        step();  // T+6: entry 3 square, low-edge saturation
        checkCtrl("t6", 0, 3, 1, 0);
        checkPoly("t6", 950, 0, 1023, 0, 1023, 53, 950, 53, 0, 300, 100, 50);

        step();  // T+7: done, back-to-back request
        checkCtrl("t7", 0, 3, 0, 1);
        checkPoly("t7", 950, 0, 1023, 0, 1023, 53, 950, 53, 0, 300, 100, 50);
        applyStimulus(1'b1, 300, 400);

        step();  // T+8: new bubble
        applyStimulus(1'b0, 0, 0);
        checkCtrl("t8", 1, 0, 1, 0);
        checkPoly("t8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 300, 400);

        step();  // T+9
        checkCtrl("t9", 0, 1, 1, 0);

        step();  // T+10: entry 0 for the new pixel
        checkCtrl("t10", 0, 2, 1, 0);
        checkPoly("t10", 190, 110, 210, 110, 210, 130, 190, 130, 0, 37, 300, 400);

        // Mid-scan reset, asserted between clock edges
        step();
        #2 reset = 1'b1;
        #1;
        checkCtrl("arst", 0, 0, 0, 0);
        checkPoly("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        checkCtrl("arst_hold", 0, 0, 0, 0);
        reset = 1'b0;

        step();
        applyStimulus(1'b1, 1, 2);
        step();
        applyStimulus(1'b0, 0, 0);
        checkCtrl("r1", 1, 0, 1, 0);
        checkPoly("r1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step();
        checkCtrl("r2", 0, 1, 1, 0);
        step();
        checkCtrl("r3", 0, 2, 1, 0);
        checkPoly("r3", 190, 110, 210, 110, 210, 130, 190, 130, 0, 37, 1, 2);
        step();
        step();
        step();
        checkCtrl("r6", 0, 3, 1, 0);
        step();
        checkCtrl("r7", 0, 3, 0, 1);
        step();
        checkCtrl("r8", 0, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/polygon_dispatcher.md
POLYGON_DISPATCHER -- requirements
Module: polygon_dispatcher

Interface
REQ-001 SHALL have parameter N_POLY, default 16, giving the number of polygon table entries scanned per pixel (range 2..256).
REQ-002 SHALL have parameter ADDR_W, default 4, giving the table address width; N_POLY <= 2**ADDR_W.
REQ-003 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: pixel_start  input  1  one-cycle request to scan a pixel.
REQ-006 SHALL have ports: pixel_x, pixel_y  input  10 each  pixel coordinates, sampled on accepted pixel_start.
REQ-007 SHALL have ports: mem_addr  output  ADDR_W  polygon table read address, registered.
REQ-008 SHALL have ports: mem_data  input  40  table word, valid exactly 1 cycle after mem_addr; [39] enable, [38] form (0 square, 1 triangle), [37:29] color, [28:19] cx, [18:9] cy, [8:0] size.
REQ-009 SHALL have ports: st3_bubble  output  1  pixel-boundary marker for downstream determinant stage.
REQ-010 SHALL have ports: st3_color  output  9; st3_pixel_x, st3_pixel_y  output  10 each; form  output  1.
REQ-011 SHALL have ports: v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y  output  10 each  polygon vertices.
REQ-012 SHALL have ports: busy  output  1  scan in progress; done  output  1  one-cycle pulse at scan end.
REQ-013 SHALL make all outputs registered.

Function
REQ-014 SHALL implement states IDLE, BUBBLE, FETCH, DRAIN.
REQ-015 In IDLE, pixel_start=1 at edge T SHALL latch pixel_x/pixel_y, move to BUBBLE, set busy=1 from T+1.
REQ-016 pixel_start while busy=1 SHALL be ignored; no queuing.
REQ-017 BUBBLE (cycle T+1) SHALL drive st3_bubble=1, st3_color=0, vertices=0, form=0, st3_pixel_x/y=latched pixel, and mem_addr=0; next state FETCH.
REQ-018 FETCH SHALL increment mem_addr by 1 per cycle up to N_POLY-1, then go to DRAIN; st3_bubble=0 in all states except BUBBLE.
REQ-019 Entry i data SHALL appear on outputs at cycle T+3+i; DRAIN lasts 1 cycle to emit the last entry.
REQ-020 done SHALL pulse at T+3+N_POLY (cycle after last entry emitted), with busy=0 and state IDLE on that same cycle; pixel_start at that edge SHALL be accepted.
REQ-021 Enabled square: v1=(cx-s,cy-s), v2=(cx+s,cy-s), v3=(cx+s,cy+s), v4=(cx-s,cy+s), form=0.
REQ-022 Enabled triangle: v1=(cx,cy-s), v2=(cx+s,cy+s), v3=(cx-s,cy+s), v4=(0,0), form=1.
REQ-023 Vertex arithmetic SHALL use 11-bit signed intermediates, saturating to [0,1023] (negative -> 0, >1023 -> 1023).
REQ-024 st3_color SHALL equal entry color; st3_pixel_x/y SHALL equal latched pixel for every emitted entry.
REQ-025 Disabled entry (enable=0) SHALL hold all st3_*/v*/form outputs at previous cycle values (re-presenting prior entry or bubble), never presenting a new polygon.
REQ-026 mem_addr SHALL remain at its last value outside FETCH.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, busy=0, done=0, st3_bubble=0, mem_addr=0, all color/vertex/pixel/form outputs 0, regardless of clk.
REQ-028 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first pixel_start after release SHALL start a fresh scan from entry 0.

Verification
REQ-029 Reset release, pixel_start at T with (100,50), N_POLY=4 -> st3_bubble=1 at T+1 only; mem_addr 0,1,2,3 at T+1..T+4; done at T+7; busy high T+1..T+6.
REQ-030 Entry 0 enabled square cx=200,cy=120,s=10,color=37 -> at T+3: v1=(190,110), v2=(210,110), v3=(210,130), v4=(190,130), form=0, st3_color=37.
REQ-031 Entry 1 triangle cx=5,cy=1020,s=20 -> v1=(5,1000), v2=(25,1023), v3=(0,1023), v4=(0,0), form=1 (both-edge saturation).
REQ-032 Entry 2 disabled following entry 1 -> outputs at T+5 identical to T+4.
REQ-033 pixel_start pulsed at T+2 during scan -> ignored, done still at T+7; pixel_start at T+7 -> new bubble at T+8.
REQ-034 reset asserted at T+4 -> all outputs 0 asynchronously, no done; after release, new scan restarts at mem_addr=0.
